// File: rtl/dmem_access_unit.sv
// Load/store access sequencer between the MEM stage and a word-wide data memory.
// Splits word-crossing accesses into two beats and hands raw load words downstream.
module dmem_access_unit #(
   parameter int ADDR_WIDTH       = 32,
   parameter bit ALLOW_MISALIGNED = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_is_store,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [1:0]            req_size,
   input  logic [31:0]           req_wdata,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [3:0]            mem_wstrb,
   output logic [31:0]           mem_wdata,
   input  logic                  mem_ack,
   input  logic [31:0]           mem_rdata,
   output logic                  resp_valid,
   output logic                  resp_err,
   output logic [31:0]           dm_data,
   output logic [1:0]            dm_block_address,
   output logic                  busy
);

   typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, DONE} state_t;

   state_t                r_state;
   state_t                w_stateNext;
   logic                  r_isStore;
   logic                  r_crossing;
   logic                  r_err;
   logic [1:0]            r_offset;
   logic [ADDR_WIDTH-1:0] r_memAddr;
   logic                  r_memWe;
   logic [3:0]            r_memWstrb;
   logic [31:0]           r_memWdata;
   logic [3:0]            r_wstrbHi;
   logic [31:0]           r_wdataHi;
   logic [31:0]           r_w0;
   logic [31:0]           r_dmData;
   logic [1:0]            r_dmBlock;

   logic [1:0]            w_offset;
   logic                  w_crossing;
   logic                  w_reqErr;
   logic                  w_accept;
   logic                  w_beatAck;
   logic [31:0]           w_sizeMask;
   logic [3:0]            w_laneMask;
   logic [63:0]           w_storeLanes;
   logic [7:0]            w_strbLanes;
   logic [63:0]           w_loadPair;

   assign w_offset   = req_addr[1:0];
   assign w_accept   = (r_state == IDLE) && req_valid;
   assign w_beatAck  = ((r_state == BEAT0) || (r_state == BEAT1)) && mem_ack;
   assign w_loadPair = {mem_rdata, r_w0} >> {r_offset, 3'b000};

   // Store data and strobes are laid out across a 64-bit two-word window.
   always_comb begin
      w_sizeMask = 32'hFFFF_FFFF;
      w_laneMask = 4'hF;
      case (req_size)
         2'd0: begin
            w_sizeMask = 32'h0000_00FF;
            w_laneMask = 4'h1;
         end
         2'd1: begin
            w_sizeMask = 32'h0000_FFFF;
            w_laneMask = 4'h3;
         end
         default: ;
      endcase
      w_storeLanes = {32'b0, req_wdata & w_sizeMask} << {w_offset, 3'b000};
      w_strbLanes  = {4'b0, w_laneMask} << w_offset;
      w_crossing   = ((req_size == 2'd2) && (w_offset != 2'd0)) ||
                     ((req_size == 2'd1) && (w_offset == 2'd3));
      w_reqErr     = (req_size == 2'd3) || (w_crossing && !ALLOW_MISALIGNED);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_stateNext;
   end

   always_comb begin
      w_stateNext = r_state;
      req_ready   = 1'b0;
      mem_req     = 1'b0;
      resp_valid  = 1'b0;
      resp_err    = 1'b0;
      case (r_state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) w_stateNext = w_reqErr ? DONE : BEAT0;
         end
         BEAT0: begin
            mem_req = 1'b1;
            if (mem_ack) w_stateNext = r_crossing ? BEAT1 : DONE;
         end
         BEAT1: begin
            mem_req = 1'b1;
            if (mem_ack) w_stateNext = DONE;
         end
         DONE: begin
            resp_valid  = 1'b1;
            resp_err    = r_err;
            w_stateNext = IDLE;
         end
         default: w_stateNext = IDLE;
      endcase
      busy = !req_ready;
   end

   // Beat registers stay frozen while waiting for ack; the upper store half is parked for beat 1.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_isStore  <= 1'b0;
         r_crossing <= 1'b0;
         r_err      <= 1'b0;
         r_offset   <= 2'd0;
         r_memAddr  <= '0;
         r_memWe    <= 1'b0;
         r_memWstrb <= 4'd0;
         r_memWdata <= 32'd0;
         r_wstrbHi  <= 4'd0;
         r_wdataHi  <= 32'd0;
         r_w0       <= 32'd0;
         r_dmData   <= 32'd0;
         r_dmBlock  <= 2'd0;
      end else if (w_accept) begin
         r_isStore  <= req_is_store;
         r_crossing <= w_crossing;
         r_err      <= w_reqErr;
         r_offset   <= w_offset;
         if (!w_reqErr) begin
            r_memAddr  <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
            r_memWe    <= req_is_store;
            r_memWstrb <= req_is_store ? w_strbLanes[3:0]   : 4'd0;
            r_memWdata <= req_is_store ? w_storeLanes[31:0] : 32'd0;
            r_wstrbHi  <= req_is_store ? w_strbLanes[7:4]   : 4'd0;
            r_wdataHi  <= req_is_store ? w_storeLanes[63:32] : 32'd0;
         end
      end else if (w_beatAck && (r_state == BEAT0) && r_crossing) begin
         r_memAddr  <= r_memAddr + ADDR_WIDTH'(4);
         r_memWstrb <= r_wstrbHi;
         r_memWdata <= r_wdataHi;
         r_w0       <= mem_rdata;
      end else if (w_beatAck) begin
         r_memWe    <= 1'b0;
         r_memWstrb <= 4'd0;
         if (!r_isStore) begin
            if (r_state == BEAT1) begin
               r_dmData  <= w_loadPair[31:0];
               r_dmBlock <= 2'd0;
            end else begin
               r_dmData  <= mem_rdata;
               r_dmBlock <= r_offset;
            end
         end
      end
   end

   assign mem_we           = r_memWe;
   assign mem_addr         = r_memAddr;
   assign mem_wstrb        = r_memWstrb;
   assign mem_wdata        = r_memWdata;
   assign dm_data          = r_dmData;
   assign dm_block_address = r_dmBlock;

endmodule

// File: tb/tb_dmem_access_unit.sv
// Self-checking bench for dmem_access_unit: directed plan cases plus randomized
// requests compared against a byte-level memory model.
module tb_dmem_access_unit;

   typedef struct {
      logic [31:0] addr;
      logic        we;
      logic [3:0]  wstrb;
      logic [31:0] wdata;
   } beat_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic        reqValid = 1'b0, reqValidB = 1'b0, reqIsStore = 1'b0;
   logic [31:0] reqAddr = 32'd0, reqWdata = 32'd0;
   logic [1:0]  reqSize = 2'd0;

   logic        reqReadyA, memReqA, memWeA, respValidA, respErrA, busyA, memAckA;
   logic [31:0] memAddrA, memWdataA, dmDataA;
   logic [31:0] memRdataA = 32'd0;
   logic [3:0]  memWstrbA;
   logic [1:0]  dmBlockA;

   logic        reqReadyB, memReqB, memWeB, respValidB, respErrB, busyB, memAckB;
   logic [31:0] memAddrB, memWdataB, dmDataB;
   logic [31:0] memRdataB = 32'd0;
   logic [3:0]  memWstrbB;
   logic [1:0]  dmBlockB;

   dmem_access_unit #(.ADDR_WIDTH(32), .ALLOW_MISALIGNED(1'b1)) dutA (
      .clk(clk), .rst(rst), .req_valid(reqValid), .req_ready(reqReadyA),
      .req_is_store(reqIsStore), .req_addr(reqAddr), .req_size(reqSize), .req_wdata(reqWdata),
      .mem_req(memReqA), .mem_we(memWeA), .mem_addr(memAddrA), .mem_wstrb(memWstrbA),
      .mem_wdata(memWdataA), .mem_ack(memAckA), .mem_rdata(memRdataA),
      .resp_valid(respValidA), .resp_err(respErrA), .dm_data(dmDataA),
      .dm_block_address(dmBlockA), .busy(busyA));

   dmem_access_unit #(.ADDR_WIDTH(32), .ALLOW_MISALIGNED(1'b0)) dutB (
      .clk(clk), .rst(rst), .req_valid(reqValidB), .req_ready(reqReadyB),
      .req_is_store(reqIsStore), .req_addr(reqAddr), .req_size(reqSize), .req_wdata(reqWdata),
      .mem_req(memReqB), .mem_we(memWeB), .mem_addr(memAddrB), .mem_wstrb(memWstrbB),
      .mem_wdata(memWdataB), .mem_ack(memAckB), .mem_rdata(memRdataB),
      .resp_valid(respValidB), .resp_err(respErrB), .dm_data(dmDataB),
      .dm_block_address(dmBlockB), .busy(busyB));

   int          assertCount = 0;
   int          failCount = 0;
   int          ackDelay = 0;
   int          waitCnt = 0;
   logic        strayAck = 1'b0;
   beat_t       beatLog[$];
   logic [31:0] memWords[logic [31:0]];
   logic [7:0]  refMem[logic [31:0]];
   logic [31:0] expDm = 32'd0;
   logic [1:0]  expBlock = 2'd0;

   int          obsLat, obsPulses, obsReqCycles;
   logic        obsErr, obsUnstable, obsBusyLow;

   function automatic logic [7:0] defByte(logic [31:0] a);
      return a[7:0] ^ a[15:8] ^ 8'h3C;
   endfunction

   function automatic logic [31:0] memRead(logic [31:0] wa);
      if (memWords.exists(wa)) return memWords[wa];
      return {defByte(wa + 32'd3), defByte(wa + 32'd2), defByte(wa + 32'd1), defByte(wa)};
   endfunction

   function automatic logic [7:0] refByte(logic [31:0] a);
      if (refMem.exists(a)) return refMem[a];
      return defByte(a);
   endfunction

   function automatic int nBytes(logic [1:0] s);
      case (s)
         2'd0:    return 1;
         2'd1:    return 2;
         default: return 4;
      endcase
   endfunction

   function automatic bit isCross(logic [31:0] a, logic [1:0] s);
      return (s != 2'd3) && ((int'(a[1:0]) + nBytes(s)) > 4);
   endfunction

   // Memory responder for dutA: configurable wait states, optional stray acks while idle.
   always_comb memAckA = (memReqA && (waitCnt == ackDelay)) || strayAck;
   assign memAckB = memReqB;

   always @(posedge clk or posedge rst) begin
      if (rst)                       waitCnt <= 0;
      else if (memReqA && memAckA)   waitCnt <= 0;
      else if (memReqA)              waitCnt <= waitCnt + 1;
      else                           waitCnt <= 0;
   end

   always @(posedge clk) begin
      if (!rst && memReqA && memAckA) begin
         logic [31:0] w;
         beatLog.push_back('{addr: memAddrA, we: memWeA, wstrb: memWstrbA, wdata: memWdataA});
         if (memWeA) begin
            w = memRead(memAddrA);
            for (int k = 0; k < 4; k++)
               if (memWstrbA[k]) w[8*k +: 8] = memWdataA[8*k +: 8];
            memWords[memAddrA] = w;
         end
      end
   end

   always @(negedge clk) begin
      memRdataA = memRead(memAddrA);
      memRdataB = memRead(memAddrB);
   end

   task automatic presetWord(input logic [31:0] wa, input logic [31:0] data);
      memWords[wa] = data;
      for (int k = 0; k < 4; k++) refMem[wa + 32'(k)] = data[8*k +: 8];
   endtask

   task automatic modelApply(input bit isStore, input logic [31:0] a, input logic [1:0] s, input logic [31:0] wd);
      logic [31:0] base;
      if (s == 2'd3) return;
      if (isStore) begin
         for (int i = 0; i < nBytes(s); i++) refMem[a + 32'(i)] = wd[8*i +: 8];
      end else begin
         base     = isCross(a, s) ? a : {a[31:2], 2'b00};
         expBlock = isCross(a, s) ? 2'd0 : a[1:0];
         for (int i = 0; i < 4; i++) expDm[8*i +: 8] = refByte(base + 32'(i));
      end
   endtask

   task automatic startReq(input bit toB, input bit isStore, input logic [31:0] addr,
                           input logic [1:0] size, input logic [31:0] wdata, output bit accepted);
      int guard = 0;
      @(negedge clk);
      reqIsStore = isStore;
      reqAddr    = addr;
      reqSize    = size;
      reqWdata   = wdata;
      if (toB) reqValidB = 1'b1;
      else     reqValid  = 1'b1;
      while (!(toB ? reqReadyB : reqReadyA) && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      accepted = toB ? reqReadyB : reqReadyA;
      @(negedge clk);
      reqValid  = 1'b0;
      reqValidB = 1'b0;
   endtask

   // Drives one request into dutA and records latency, pulses and beat stability.
   task automatic applyStimulus(input bit isStore, input logic [31:0] addr, input logic [1:0] size,
                                input logic [31:0] wdata, input int delay);
      bit          acc;
      logic        pReq = 1'b0, pAck = 1'b0, pWe = 1'b0;
      logic [31:0] pA = 32'd0, pW = 32'd0;
      logic [3:0]  pS = 4'd0;
      ackDelay = delay;
      beatLog.delete();
      obsLat = 0; obsPulses = 0; obsReqCycles = 0;
      obsErr = 1'b0; obsUnstable = 1'b0; obsBusyLow = 1'b0;
      startReq(1'b0, isStore, addr, size, wdata, acc);
      if (acc) begin
         for (int c = 1; c <= 80; c++) begin
            if (memReqA) begin
               obsReqCycles++;
               if (pReq && !pAck && (memAddrA !== pA || memWdataA !== pW || memWstrbA !== pS || memWeA !== pWe))
                  obsUnstable = 1'b1;
            end
            pReq = memReqA; pAck = memAckA; pA = memAddrA; pW = memWdataA; pS = memWstrbA; pWe = memWeA;
            if (obsLat == 0 && !busyA) obsBusyLow = 1'b1;
            if (respValidA) begin
               obsPulses++;
               if (obsLat == 0) begin
                  obsLat = c;
                  obsErr = respErrA;
               end
            end
            if (obsLat != 0 && c >= obsLat + 3) break;
            @(negedge clk);
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      assertCount++;
      if (reqReadyA !== 1'b1) begin failCount++; $display("[TB] FAIL reset_ready: got %b expected 1", reqReadyA); end
      assertCount++;
      if ({memReqA, memWeA, respValidA, respErrA, busyA} !== 5'b0) begin failCount++;
         $display("[TB] FAIL reset_ctrl: got %b expected 00000", {memReqA, memWeA, respValidA, respErrA, busyA}); end
      assertCount++;
      if (memAddrA !== 32'd0) begin failCount++; $display("[TB] FAIL reset_addr: got %h expected 0", memAddrA); end
      assertCount++;
      if ({memWstrbA, memWdataA} !== 36'd0) begin failCount++;
         $display("[TB] FAIL reset_wlanes: got %h/%h expected 0/0", memWstrbA, memWdataA); end
      assertCount++;
      if ({dmDataA, dmBlockA} !== 34'd0) begin failCount++;
         $display("[TB] FAIL reset_dm: got %h/%h expected 0/0", dmDataA, dmBlockA); end
      rst = 1'b0;
      @(negedge clk);
      assertCount++;
      if ({reqReadyA, memReqA, reqReadyB} !== 3'b101) begin failCount++;
         $display("[TB] FAIL post_reset_idle: got %b expected 101", {reqReadyA, memReqA, reqReadyB}); end
   endtask

   task automatic test_loads();
      logic [31:0] addrs[3], datas[3];
      logic [1:0]  sizes[3], blocks[3];
      int          lats[3];
      addrs  = '{32'h101, 32'h102, 32'h103};
      sizes  = '{2'd0, 2'd2, 2'd1};
      datas  = '{32'h4433_2211, 32'h6655_4433, 32'h7766_5544};
      blocks = '{2'd1, 2'd0, 2'd0};
      lats   = '{2, 3, 3};
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b0, addrs[i], sizes[i], 32'd0, 0);
         modelApply(1'b0, addrs[i], sizes[i], 32'd0);
         assertCount++;
         if (obsLat !== lats[i] || obsPulses !== 1 || obsErr !== 1'b0) begin failCount++;
            $display("[TB] FAIL load%0d_timing: got lat %0d pulses %0d err %b expected lat %0d pulses 1 err 0",
                     i, obsLat, obsPulses, obsErr, lats[i]); end
         assertCount++;
         if (dmDataA !== datas[i] || dmBlockA !== blocks[i]) begin failCount++;
            $display("[TB] FAIL load%0d_data: got %h/%0d expected %h/%0d", i, dmDataA, dmBlockA, datas[i], blocks[i]); end
         assertCount++;
         if (beatLog.size() !== lats[i] - 1 || beatLog[0].addr !== 32'h100 || beatLog[0].wstrb !== 4'd0 ||
             (lats[i] == 3 && beatLog[1].addr !== 32'h104)) begin failCount++;
            $display("[TB] FAIL load%0d_beats: got %0d beats first %h expected %0d beats first 100",
                     i, beatLog.size(), beatLog.size() > 0 ? beatLog[0].addr : 32'hX, lats[i] - 1); end
      end
   endtask

   task automatic test_no_misaligned();
      bit          acc, errSeen, sawReq;
      int          lat, pulses;
      logic [31:0] addrs[3];
      logic [1:0]  sizes[3];
      addrs = '{32'h102, 32'h103, 32'h100};
      sizes = '{2'd2, 2'd1, 2'd2};
      for (int i = 0; i < 3; i++) begin
         startReq(1'b1, 1'b0, addrs[i], sizes[i], 32'd0, acc);
         lat = 0; pulses = 0; errSeen = 1'b0; sawReq = 1'b0;
         for (int c = 1; c <= 6; c++) begin
            if (memReqB) sawReq = 1'b1;
            if (respValidB) begin
               pulses++;
               if (lat == 0) begin lat = c; errSeen = respErrB; end
            end
            @(negedge clk);
         end
         assertCount++;
         if (i < 2 && (lat !== 1 || errSeen !== 1'b1 || sawReq !== 1'b0 || pulses !== 1 || dmDataB !== 32'd0)) begin
            failCount++;
            $display("[TB] FAIL nomis%0d_err: got lat %0d err %b memreq %b pulses %0d dm %h expected 1 1 0 1 0",
                     i, lat, errSeen, sawReq, pulses, dmDataB); end
         else if (i == 2 && (lat !== 2 || errSeen !== 1'b0 || dmDataB !== 32'h4433_2211 || dmBlockB !== 2'd0)) begin
            failCount++;
            $display("[TB] FAIL nomis_aligned: got lat %0d err %b dm %h blk %0d expected 2 0 44332211 0",
                     lat, errSeen, dmDataB, dmBlockB); end
      end
   endtask

   task automatic test_reserved_size();
      for (int st = 0; st < 2; st++) begin
         applyStimulus(st[0], 32'h104, 2'd3, 32'h1234_5678, 0);
         assertCount++;
         if (obsLat !== 1 || obsErr !== 1'b1 || obsPulses !== 1 || beatLog.size() !== 0 || obsReqCycles !== 0) begin
            failCount++;
            $display("[TB] FAIL reserved%0d: got lat %0d err %b pulses %0d beats %0d expected 1 1 1 0",
                     st, obsLat, obsErr, obsPulses, beatLog.size()); end
         assertCount++;
         if (dmDataA !== expDm || dmBlockA !== expBlock) begin failCount++;
            $display("[TB] FAIL reserved%0d_dm: got %h expected %h", st, dmDataA, expDm); end
      end
   endtask

   task automatic test_store_split();
      applyStimulus(1'b1, 32'h101, 2'd2, 32'hAABB_CCDD, 0);
      modelApply(1'b1, 32'h101, 2'd2, 32'hAABB_CCDD);
      assertCount++;
      if (obsLat !== 3 || obsErr !== 1'b0 || beatLog.size() !== 2) begin failCount++;
         $display("[TB] FAIL store_split_shape: got lat %0d err %b beats %0d expected 3 0 2", obsLat, obsErr, beatLog.size()); end
      else begin
         assertCount++;
         if (beatLog[0].addr !== 32'h100 || beatLog[0].we !== 1'b1 || beatLog[0].wstrb !== 4'b1110 ||
             beatLog[0].wdata !== 32'hBBCC_DD00) begin failCount++;
            $display("[TB] FAIL store_beat0: got %h/%b/%b/%h expected 00000100/1/1110/bbccdd00",
                     beatLog[0].addr, beatLog[0].we, beatLog[0].wstrb, beatLog[0].wdata); end
         assertCount++;
         if (beatLog[1].addr !== 32'h104 || beatLog[1].we !== 1'b1 || beatLog[1].wstrb !== 4'b0001 ||
             beatLog[1].wdata !== 32'h0000_00AA) begin failCount++;
            $display("[TB] FAIL store_beat1: got %h/%b/%b/%h expected 00000104/1/0001/000000aa",
                     beatLog[1].addr, beatLog[1].we, beatLog[1].wstrb, beatLog[1].wdata); end
      end
      assertCount++;
      if (dmDataA !== expDm || dmBlockA !== expBlock) begin failCount++;
         $display("[TB] FAIL store_dm_kept: got %h expected %h", dmDataA, expDm); end
   endtask

   task automatic test_wait_states();
      logic bad = 1'b0;
      strayAck = 1'b1;
      repeat (3) begin
         @(negedge clk);
         if (memReqA || respValidA || !reqReadyA) bad = 1'b1;
      end
      strayAck = 1'b0;
      @(negedge clk);
      if (memReqA || respValidA || !reqReadyA) bad = 1'b1;
      assertCount++;
      if (bad !== 1'b0) begin failCount++; $display("[TB] FAIL stray_ack: got disturbance 1 expected 0"); end
      applyStimulus(1'b0, 32'h200, 2'd2, 32'd0, 3);
      modelApply(1'b0, 32'h200, 2'd2, 32'd0);
      assertCount++;
      if (obsReqCycles !== 4 || obsUnstable !== 1'b0 || obsBusyLow !== 1'b0) begin failCount++;
         $display("[TB] FAIL wait_hold: got req cycles %0d unstable %b busy_low %b expected 4 0 0",
                  obsReqCycles, obsUnstable, obsBusyLow); end
      assertCount++;
      if (obsLat !== 5 || obsPulses !== 1 || beatLog.size() !== 1 || beatLog[0].addr !== 32'h200) begin failCount++;
         $display("[TB] FAIL wait_resp: got lat %0d pulses %0d beats %0d expected 5 1 1", obsLat, obsPulses, beatLog.size()); end
      assertCount++;
      if (dmDataA !== expDm || dmBlockA !== expBlock) begin failCount++;
         $display("[TB] FAIL wait_data: got %h expected %h", dmDataA, expDm); end
   endtask

   task automatic test_wrap();
      applyStimulus(1'b0, 32'hFFFF_FFFE, 2'd2, 32'd0, 0);
      modelApply(1'b0, 32'hFFFF_FFFE, 2'd2, 32'd0);
      assertCount++;
      if (beatLog.size() !== 2 || beatLog[0].addr !== 32'hFFFF_FFFC || beatLog[1].addr !== 32'h0 || obsLat !== 3) begin
         failCount++;
         $display("[TB] FAIL wrap_beats: got %0d beats lat %0d expected 2 beats fffffffc,00000000 lat 3",
                  beatLog.size(), obsLat); end
      assertCount++;
      if (dmDataA !== expDm || dmBlockA !== 2'd0) begin failCount++;
         $display("[TB] FAIL wrap_data: got %h/%0d expected %h/0", dmDataA, dmBlockA, expDm); end
   endtask

   task automatic test_reset_mid_beat();
      bit   acc, reached = 1'b0;
      int   pulses = 0;
      ackDelay = 4;
      startReq(1'b0, 1'b0, 32'h102, 2'd2, 32'd0, acc);
      for (int c = 0; c < 30 && !reached; c++) begin
         if (memReqA && memAddrA == 32'h104) reached = 1'b1;
         else @(negedge clk);
      end
      assertCount++;
      if (reached !== 1'b1) begin failCount++; $display("[TB] FAIL rst_mid_reach: got 0 expected 1"); end
      rst = 1'b1;
      #1;
      assertCount++;
      if ({memReqA, reqReadyA, busyA} !== 3'b010) begin failCount++;
         $display("[TB] FAIL rst_mid_abort: got %b expected 010", {memReqA, reqReadyA, busyA}); end
      @(negedge clk);
      rst = 1'b0;
      repeat (4) begin
         @(negedge clk);
         if (respValidA) pulses++;
      end
      expDm = 32'd0;
      expBlock = 2'd0;
      assertCount++;
      if (pulses !== 0 || dmDataA !== 32'd0) begin failCount++;
         $display("[TB] FAIL rst_mid_quiet: got pulses %0d dm %h expected 0 0", pulses, dmDataA); end
      applyStimulus(1'b0, 32'h100, 2'd2, 32'd0, 0);
      modelApply(1'b0, 32'h100, 2'd2, 32'd0);
      assertCount++;
      if (obsLat !== 2 || obsPulses !== 1 || dmDataA !== 32'hBBCC_DD11 || dmDataA !== expDm) begin failCount++;
         $display("[TB] FAIL rst_mid_recover: got lat %0d dm %h expected 2 bbccdd11", obsLat, dmDataA); end
   endtask

   task automatic test_random();
      logic [31:0] a, wd, eAddr, eWd, rel;
      logic [1:0]  s;
      logic [3:0]  eStrb;
      bit          st;
      int          dly, nb, n;
      for (int it = 0; it < 40; it++) begin
         a   = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF8 + 32'($urandom_range(0, 7)))
                                           : (32'h100 + 32'($urandom_range(0, 31)));
         s   = 2'($urandom_range(0, 3));
         st  = 1'($urandom_range(0, 1));
         wd  = $urandom;
         dly = $urandom_range(0, 2);
         n   = nBytes(s);
         nb  = (s == 2'd3) ? 0 : (isCross(a, s) ? 2 : 1);
         applyStimulus(st, a, s, wd, dly);
         modelApply(st, a, s, wd);
         assertCount++;
         if (obsLat !== ((s == 2'd3) ? 1 : 1 + nb * (dly + 1)) || obsErr !== (s == 2'd3) || obsPulses !== 1) begin
            failCount++;
            $display("[TB] FAIL rand%0d_resp: got lat %0d err %b pulses %0d expected lat %0d err %b pulses 1 (addr %h size %0d)",
                     it, obsLat, obsErr, obsPulses, (s == 2'd3) ? 1 : 1 + nb * (dly + 1), s == 2'd3, a, s); end
         assertCount++;
         if (beatLog.size() !== nb) begin failCount++;
            $display("[TB] FAIL rand%0d_nbeats: got %0d expected %0d", it, beatLog.size(), nb); end
         for (int j = 0; j < nb && j < beatLog.size(); j++) begin
            eAddr = {a[31:2], 2'b00} + 32'(4 * j);
            eStrb = 4'd0;
            eWd   = 32'd0;
            for (int k = 0; k < 4; k++) begin
               rel = eAddr + 32'(k) - a;
               if (st && rel < 32'(n)) begin
                  eStrb[k]      = 1'b1;
                  eWd[8*k +: 8] = wd[8*rel[1:0] +: 8];
               end
            end
            assertCount++;
            if (beatLog[j].addr !== eAddr || beatLog[j].we !== st || beatLog[j].wstrb !== eStrb ||
                (st && beatLog[j].wdata !== eWd)) begin failCount++;
               $display("[TB] FAIL rand%0d_beat%0d: got %h/%b/%b/%h expected %h/%b/%b/%h", it, j,
                        beatLog[j].addr, beatLog[j].we, beatLog[j].wstrb, beatLog[j].wdata, eAddr, st, eStrb, eWd); end
         end
         assertCount++;
         if (dmDataA !== expDm || dmBlockA !== expBlock) begin failCount++;
            $display("[TB] FAIL rand%0d_dm: got %h/%0d expected %h/%0d", it, dmDataA, dmBlockA, expDm, expBlock); end
      end
   endtask

   initial begin
      presetWord(32'h100, 32'h4433_2211);
      presetWord(32'h104, 32'h8877_6655);
      test_reset();
      test_loads();
      test_no_misaligned();
      test_reserved_size();
      test_store_split();
      test_wait_states();
      test_wrap();
      test_reset_mid_beat();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule

// File: doc/dmem_access_unit.md
Name: dmem_access_unit

Overview:
Load/store access sequencer between the MEM pipeline stage and the word-wide data memory. It sits directly upstream of the load extension handler.
- Takes one byte-addressed load/store request at a time.
- Splits word-boundary-crossing accesses into two word beats.
- Drives a valid/ack memory handshake.
- For loads, delivers a raw 32-bit word plus a 2-bit block address for sign/zero extension by the downstream handler.

Parameters:
ADDR_WIDTH, 32, byte address width; word index is ADDR_WIDTH-2 bits.
ALLOW_MISALIGNED, 1, 1 = split crossing accesses into two beats; 0 = flag crossing accesses as errors with no memory traffic.

Ports:
clk  in  1  single clock; all state on rising edge.
rst  in  1  asynchronous, active-high reset.
req_valid  in  1  request present.
req_ready  out  1  unit idle; a request is accepted when req_valid && req_ready.
req_is_store  in  1  1 = store, 0 = load.
req_addr  in  ADDR_WIDTH  byte address.
req_size  in  2  0 = byte, 1 = halfword, 2 = word, 3 = reserved.
req_wdata  in  32  store data, right-aligned.
mem_req  out  1  memory beat request.
mem_we  out  1  write enable for the beat.
mem_addr  out  ADDR_WIDTH  word-aligned byte address; bits [1:0] = 0.
mem_wstrb  out  4  byte-lane write strobes; 0 on loads.
mem_wdata  out  32  lane-shifted store data.
mem_ack  in  1  beat completes in the cycle mem_req && mem_ack.
mem_rdata  in  32  read data, valid in the ack cycle.
resp_valid  out  1  one-cycle completion pulse.
resp_err  out  1  valid with resp_valid; reserved size or disallowed crossing.
dm_data  out  32  load word for the downstream handler.
dm_block_address  out  2  byte offset for the downstream handler.
busy  out  1  pipeline stall; equals !req_ready.

Behaviour:
- Reset (async, immediate): state = IDLE. req_ready = 1. mem_req, mem_we, resp_valid, resp_err = 0. mem_addr, mem_wstrb, mem_wdata, dm_data = 0. dm_block_address = 0. All request/beat registers cleared.
- States: IDLE, BEAT0, BEAT1, DONE. req_ready = (state == IDLE).
- Offset o = req_addr[1:0].
- crossing = (size == 2 && o != 0) || (size == 1 && o == 3).
- IDLE -> accept:
  - size 3, or crossing with ALLOW_MISALIGNED = 0 -> DONE with err = 1; no memory beat is issued.
  - Otherwise -> BEAT0, with mem_addr = {req_addr[ADDR_WIDTH-1:2], 2'b00}.
- BEAT0/BEAT1: mem_req = 1. mem_addr, mem_we, mem_wstrb and mem_wdata are registered and held stable until ack. Unlimited wait states.
- BEAT0 ack: if crossing -> BEAT1 with mem_addr + 4 (modulo 2^ADDR_WIDTH, wraps to 0); capture rdata into w0. Otherwise -> DONE.
- BEAT1 ack -> DONE; capture w1.
- mem_req drops in the cycle after the final ack. No back-to-back beats across requests.
- DONE: resp_valid = 1 for exactly one cycle, then IDLE. The next request can be accepted the cycle after DONE.
- Latency with zero-wait memory: accept at cycle N, beat at N+1, resp_valid at N+2. Crossing access: resp_valid at N+3.
- Store lanes: 64-bit S = {32'b0, wdata masked to size} << (8*o). Mask M = (size mask 1/3/F) << o, as 8 bits.
  - Beat0: wdata = S[31:0], wstrb = M[3:0].
  - Beat1: wdata = S[63:32], wstrb = M[7:4].
- Load, non-crossing: dm_data = mem_rdata captured at ack; dm_block_address = o.
- Load, crossing: dm_data = ({w1, w0} >> 8*o)[31:0]; dm_block_address = 0.
- dm_data and dm_block_address are held from DONE until the next load completes.
- Stores and errors leave dm_data unchanged.
- mem_ack outside mem_req is ignored.
- req_valid while busy is ignored; the requester must hold it.
- Reset mid-beat aborts the access; a half-written crossing store is not rolled back.

Test Plan:
- Memory: 0x100 = 0x44332211, 0x104 = 0x88776655, zero-wait ack.
  - LB 0x101 -> one beat at 0x100; dm_data = 0x44332211; block 01; resp_valid at N+2; err 0.
  - LW 0x102 -> beats at 0x100 then 0x104; dm_data = 0x66554433; block 00; resp_valid at N+3.
  - LH 0x103 -> two beats; dm_data = 0x77665544; block 00.
- SW 0xAABBCCDD at 0x101 -> beat0 addr 0x100, wstrb 1110, wdata 0xBBCCDD00; beat1 addr 0x104, wstrb 0001, wdata 0x000000AA.
- LW 0x200 with ack delayed 3 cycles -> mem_req and addr 0x200 stable for 4 cycles; busy high throughout; one resp_valid pulse.
- size = 3, or ALLOW_MISALIGNED = 0 with LW 0x102 -> no mem_req; resp_valid with resp_err = 1 at N+1.
- rst pulsed during BEAT1 of a crossing load -> mem_req = 0 immediately; req_ready = 1; no resp_valid; the next LW 0x100 works normally.
- LW 0xFFFFFFFE -> beats at 0xFFFFFFFC then 0x00000000 (wrap).
